mcpu_core_hs: RTL and testbench

Handshaked, parametrised successor of the MCPU core. It executes the same 8-bit MOV/CMOV/IMM instruction set. Instruction fetch and data RAM are reached over valid/ack handshakes with arbitrary wait states, and the tri-state data bus is replaced by separate read and write buses. It sits between the instruction ROM, the data RAM controller and the existing MCPU ALU, which it instantiates.

---
 rtl/mcpu_core_hs.sv | 243 ++++++++++++++++++++++++
 tb/tb_mcpu_core_hs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_core_hs.sv
// mcpu_core_hs: handshaked MCPU core executing the 8-bit MOV/CMOV/IMM set.
// Instruction fetch uses a valid strobe and data RAM uses a req/ack handshake;
// both tolerate arbitrary wait states. Also holds the MCPU ALU it drives.

// MCPU ALU: combinational. op[2:0] selects the result and op[3] selects the flag.
// The flag is either the external sense input or a zero test on the result.
module mcpu_alu #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic [3:0]   op_i,
    input  logic         sense_i,
    output logic [W-1:0] d_o,
    output logic         f_o
);
    // Result selection by low opcode bits
    always_comb begin
        d_o = '0;
        case (op_i[2:0])
            3'd0:    d_o = a_i + b_i;
            3'd1:    d_o = a_i - b_i;
            3'd2:    d_o = a_i & b_i;
            3'd3:    d_o = a_i | b_i;
            3'd4:    d_o = a_i ^ b_i;
            3'd5:    d_o = x_i;
            3'd6:    d_o = y_i;
            default: d_o = ~a_i;
        endcase
    end

    assign f_o = op_i[3] ? (d_o == '0) : sense_i;
endmodule

module mcpu_core_hs #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    output logic [DATA_WIDTH-1:0] irom_addr,
    input  logic [7:0]            irom_data,
    input  logic                  irom_valid,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    input  logic                  sense,
    input  logic [DATA_WIDTH-1:0] alu_x,
    input  logic [DATA_WIDTH-1:0] alu_y,
    output logic                  retire
);
    typedef enum logic [1:0] {EXEC, RD_WAIT, WR_WAIT} state_t;

    localparam logic [2:0] CODE_RAM = 3'd2;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, imm_q, imm_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [DATA_WIDTH-1:0] i_q, i_d, j_q, j_d, k_q, k_d, wdata_q, wdata_d;
    logic                  last_imm_q, last_imm_d, req_q, req_d, we_q, we_d;
    logic                  retire_q, retire_d;
    logic [2:0]            dst_q, dst_d;

    logic [DATA_WIDTH-1:0] alu_d_out, src_val, pc_inc, wr_val;
    logic                  alu_f_out, wr_en;
    logic [2:0]            wr_code;

    mcpu_alu #(.W(DATA_WIDTH)) u_alu (
        .a_i     (alu_a_q),
        .b_i     (alu_b_q),
        .x_i     (alu_x),
        .y_i     (alu_y),
        .op_i    (imm_q[3:0]),
        .sense_i (sense),
        .d_o     (alu_d_out),
        .f_o     (alu_f_out)
    );

    assign pc_inc = pc_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    // Source operand multiplexer; RAM is never read through here
    always_comb begin
        src_val = '0;
        case (irom_data[2:0])
            3'd0:    src_val = pc_q;
            3'd1:    src_val = addr_q;
            3'd3:    src_val = imm_q;
            3'd4:    src_val = alu_d_out;
            3'd5:    src_val = i_q;
            3'd6:    src_val = j_q;
            3'd7:    src_val = k_q;
            default: src_val = '0;
        endcase
    end

    // Issue/handshake FSM plus register-file writeback; everything holds by default
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        imm_d      = imm_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        wdata_d    = wdata_q;
        last_imm_d = last_imm_q;
        req_d      = req_q;
        we_d       = we_q;
        dst_d      = dst_q;
        retire_d   = 1'b0;
        wr_en      = 1'b0;
        wr_code    = 3'd0;
        wr_val     = '0;

        case (state_q)
            EXEC: begin
                if (run && irom_valid) begin
                    if (irom_data[7]) begin
                        // Consecutive IMM bytes build wide constants 7 bits at a time
                        imm_d      = last_imm_q ? {imm_q[DATA_WIDTH-8:0], irom_data[6:0]}
                                                : {{(DATA_WIDTH-7){1'b0}}, irom_data[6:0]};
                        last_imm_d = 1'b1;
                        pc_d       = pc_inc;
                        retire_d   = 1'b1;
                    end else begin
                        last_imm_d = 1'b0;
                        if (irom_data[6] && !alu_f_out) begin
                            pc_d     = pc_inc;
                            retire_d = 1'b1;
                        end else if (irom_data[2:0] == CODE_RAM) begin
                            dst_d   = irom_data[5:3];
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            state_d = RD_WAIT;
                        end else if (irom_data[5:3] == CODE_RAM) begin
                            wdata_d = src_val;
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            state_d = WR_WAIT;
                        end else begin
                            wr_en   = 1'b1;
                            wr_code = irom_data[5:3];
                            wr_val  = src_val;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (dmem_ack) begin
                    if (dst_q == CODE_RAM) begin
                        // RAM-to-RAM: keep req high and turn the read into a write
                        wdata_d = dmem_rdata;
                        we_d    = 1'b1;
                        state_d = WR_WAIT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_code = dst_q;
                        wr_val  = dmem_rdata;
                        req_d   = 1'b0;
                        state_d = EXEC;
                    end
                end
            end
            WR_WAIT: begin
                if (dmem_ack) begin
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    pc_d     = pc_inc;
                    retire_d = 1'b1;
                    state_d  = EXEC;
                end
            end
            default: state_d = EXEC;
        endcase

        // Register writeback; a PC destination suppresses the increment
        if (wr_en) begin
            retire_d = 1'b1;
            pc_d     = pc_inc;
            case (wr_code)
                3'd0:    pc_d    = wr_val;
                3'd1:    addr_d  = wr_val;
                3'd3:    alu_a_d = wr_val;
                3'd4:    alu_b_d = wr_val;
                3'd5:    i_d     = wr_val;
                3'd6:    j_d     = wr_val;
                3'd7:    k_d     = wr_val;
                default: ;
            endcase
        end
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EXEC;
            pc_q       <= '0;
            addr_q     <= '0;
            imm_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            wdata_q    <= '0;
            last_imm_q <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            retire_q   <= 1'b0;
            dst_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            imm_q      <= imm_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            wdata_q    <= wdata_d;
            last_imm_q <= last_imm_d;
            req_q      <= req_d;
            we_q       <= we_d;
            retire_q   <= retire_d;
            dst_q      <= dst_d;
        end
    end

    assign irom_addr  = pc_q;
    assign dmem_addr  = addr_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_wdata = wdata_q;
    assign retire     = retire_q;
endmodule

// File: tb/tb_mcpu_core_hs.sv
// Directed bench for mcpu_core_hs; internal registers are observed by moving
// them to ADDR/RAM/PC and checking the corresponding output ports.
`timescale 1ns/1ps
module tb_mcpu_core_hs;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic [31:0] irom_addr;
    logic [7:0]  irom_data = 8'h00;
    logic        irom_valid = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'h0;
    logic        dmem_ack = 1'b0;
    logic        sense = 1'b0;
    logic [31:0] alu_x = 32'h0;
    logic [31:0] alu_y = 32'h0;
    logic        retire;

    int n_cmp = 0;
    int n_fail = 0;

    mcpu_core_hs #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .irom_addr  (irom_addr),
        .irom_data  (irom_data),
        .irom_valid (irom_valid),
        .dmem_addr  (dmem_addr),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .sense      (sense),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .retire     (retire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction byte for exactly one rising edge
    task automatic issue(input logic [7:0] b);
        irom_data  = b;
        irom_valid = 1'b1;
        run        = 1'b1;
        tick();
        irom_valid = 1'b0;
        $display("issue %h -> pc=%h retire=%0b req=%0b", b, irom_addr, retire, dmem_req);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        chk("rst_pc", irom_addr, 32'h0);
        chk("rst_req_async", {31'b0, dmem_req}, 32'h0);
        reset_n = 1'b1;
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_retire", {31'b0, retire}, 32'h0);
        chk("rst_we", {31'b0, dmem_we}, 32'h0);

        // IMM 0x05, IMM 0x03 -> IMM = 0x283; MOV IMM->I
        issue(8'h85);
        chk("imm1_retire", {31'b0, retire}, 32'h1);
        chk("imm1_pc", irom_addr, 32'h1);
        issue(8'h83);
        chk("imm2_retire", {31'b0, retire}, 32'h1);
        chk("imm2_pc", irom_addr, 32'h2);
        issue(8'h2B);
        chk("movi_retire", {31'b0, retire}, 32'h1);
        chk("movi_pc", irom_addr, 32'h3);

        // ADDR = 0x10
        issue(8'h90);
        issue(8'h0B);
        chk("addr_set", dmem_addr, 32'h10);
        chk("addr_pc", irom_addr, 32'h5);

        // MOV I->RAM with 3 wait cycles
        issue(8'h15);
        chk("wr_req", {31'b0, dmem_req}, 32'h1);
        chk("wr_we", {31'b0, dmem_we}, 32'h1);
        chk("wr_wdata", dmem_wdata, 32'h283);
        chk("wr_noretire", {31'b0, retire}, 32'h0);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("wr_hold_req", {31'b0, dmem_req}, 32'h1);
            chk("wr_hold_wdata", dmem_wdata, 32'h283);
            chk("wr_hold_addr", dmem_addr, 32'h10);
            chk("wr_hold_noretire", {31'b0, retire}, 32'h0);
        end
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("wr_done_retire", {31'b0, retire}, 32'h1);
        chk("wr_done_req", {31'b0, dmem_req}, 32'h0);
        chk("wr_done_pc", irom_addr, 32'h6);
        tick();
        chk("wr_retire_pulse", {31'b0, retire}, 32'h0);

        // MOV RAM->J then J->ADDR
        issue(8'h32);
        chk("rd_req", {31'b0, dmem_req}, 32'h1);
        chk("rd_we", {31'b0, dmem_we}, 32'h0);
        dmem_rdata = 32'hDEADBEEF;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack   = 1'b0;
        chk("rd_retire", {31'b0, retire}, 32'h1);
        chk("rd_req_drop", {31'b0, dmem_req}, 32'h0);
        chk("rd_pc", irom_addr, 32'h7);
        issue(8'h0E);
        chk("j_value", dmem_addr, 32'hDEADBEEF);
        chk("j_pc", irom_addr, 32'h8);

        // CMOV IMM->PC, flag false then true
        issue(8'hC0);
        sense = 1'b0;
        issue(8'h43);
        chk("cmov_f0_pc", irom_addr, 32'hA);
        chk("cmov_f0_retire", {31'b0, retire}, 32'h1);
        sense = 1'b1;
        issue(8'h43);
        sense = 1'b0;
        chk("cmov_f1_pc", irom_addr, 32'h40);
        chk("cmov_f1_retire", {31'b0, retire}, 32'h1);

        // RAM->RAM zero-wait
        issue(8'h12);
        chk("rr_rd_req", {31'b0, dmem_req}, 32'h1);
        chk("rr_rd_we", {31'b0, dmem_we}, 32'h0);
        dmem_rdata = 32'h12345678;
        dmem_ack   = 1'b1;
        tick();
        chk("rr_wr_req", {31'b0, dmem_req}, 32'h1);
        chk("rr_wr_we", {31'b0, dmem_we}, 32'h1);
        chk("rr_wr_wdata", dmem_wdata, 32'h12345678);
        chk("rr_wr_addr", dmem_addr, 32'hDEADBEEF);
        chk("rr_mid_noretire", {31'b0, retire}, 32'h0);
        tick();
        dmem_ack = 1'b0;
        chk("rr_retire", {31'b0, retire}, 32'h1);
        chk("rr_req_drop", {31'b0, dmem_req}, 32'h0);
        chk("rr_pc", irom_addr, 32'h41);

        // irom_valid low for 5 cycles
        run        = 1'b1;
        irom_valid = 1'b0;
        for (int w = 0; w < 5; w++) begin
            tick();
            chk("novalid_pc", irom_addr, 32'h41);
            chk("novalid_retire", {31'b0, retire}, 32'h0);
        end

        // run low during RD_WAIT: read completes, no further issue
        issue(8'h3A);
        run        = 1'b0;
        irom_valid = 1'b1;
        irom_data  = 8'h85;
        tick();
        tick();
        chk("runlow_req", {31'b0, dmem_req}, 32'h1);
        dmem_rdata = 32'hCAFEF00D;
        dmem_ack   = 1'b1;
        tick();
        dmem_ack   = 1'b0;
        chk("runlow_retire", {31'b0, retire}, 32'h1);
        chk("runlow_pc", irom_addr, 32'h42);
        tick();
        tick();
        chk("runlow_hold_pc", irom_addr, 32'h42);
        chk("runlow_hold_retire", {31'b0, retire}, 32'h0);
        irom_valid = 1'b0;
        issue(8'h0F);
        chk("k_value", dmem_addr, 32'hCAFEF00D);
        chk("k_pc", irom_addr, 32'h43);

        // PC wrap: IMM = 0xFFFFFFFF, MOV IMM->PC, IMM byte
        for (int b = 0; b < 5; b++) issue(8'hFF);
        chk("pre_wrap_pc", irom_addr, 32'h48);
        issue(8'h03);
        chk("pc_max", irom_addr, 32'hFFFFFFFF);
        issue(8'h80);
        chk("pc_wrap", irom_addr, 32'h0);

        // Reset during WR_WAIT
        issue(8'h85);
        issue(8'h13);
        chk("pre_rst_req", {31'b0, dmem_req}, 32'h1);
        chk("pre_rst_wdata", dmem_wdata, 32'h5);
        chk("pre_rst_pc", irom_addr, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_req", {31'b0, dmem_req}, 32'h0);
        chk("arst_we", {31'b0, dmem_we}, 32'h0);
        chk("arst_wdata", dmem_wdata, 32'h0);
        chk("arst_pc", irom_addr, 32'h0);
        tick();
        reset_n = 1'b1;
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("arst_no_completion", {31'b0, retire}, 32'h0);
        // IMM cleared by reset: MOV IMM->PC lands on 0
        issue(8'h03);
        chk("arst_imm_pc", irom_addr, 32'h0);
        chk("arst_imm_retire", {31'b0, retire}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
